// File: rtl/wb_line_mem_slave.sv
// wb_line_mem_slave: Wishbone single-transfer slave over a line-addressed 128-bit memory with programmable wait states
// Ports: CLK bus clock; RST_N synchronous active-low reset;
//        CYC/STB/WE/ADR/SEL/DAT_M request from master; DAT_S/ACK/RTY response to master.
// Optional: define WB_LINE_MEM_RANGE_CHECK_EN to answer ADR >= DEPTH_LINES with a one-cycle RTY
//           (no write, DAT_S=0) instead of aliasing the address modulo DEPTH_LINES.
module wb_line_mem_slave #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [11:0]  ADR,
  input  logic [15:0]  SEL,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK,
  output logic         RTY
);
  localparam int AW = $clog2(DEPTH_LINES);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic cap, resp, req, oob;
  logic we_q;
  logic [11:0] adr_q;
  logic [15:0] sel_q;
  logic [127:0] dat_q;
  logic [127:0] mem [DEPTH_LINES];
  logic [AW-1:0] line;
  assign req = CYC & STB;
  assign line = adr_q[AW-1:0];
`ifdef WB_LINE_MEM_RANGE_CHECK_EN
  // DEPTH_LINES is a power of two, so any set bit above the index means out of range
  assign oob = |(adr_q >> AW);
`else
  logic unused_hi;
  assign unused_hi = |(adr_q >> AW);
  assign oob = 1'b0;
`endif
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    cap = 1'b0;
    resp = 1'b0;
    unique case (state)
      IDLE: begin
        cap = req;
        state_d = !req ? IDLE : (LATENCY == 0) ? RESP : WAIT;
        cnt_d = req ? CNT_INIT : cnt;
      end
      WAIT: begin
        state_d = !req ? IDLE : (cnt == 4'd0) ? RESP : WAIT;
        cnt_d = (req && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      end
      RESP: begin
        resp = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt <= 4'd0;
      ACK <= 1'b0;
      RTY <= 1'b0;
      DAT_S <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      ACK <= resp & ~oob;
      RTY <= resp & oob;
      DAT_S <= (resp && !we_q && !oob) ? mem[line] : '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (cap) begin
      we_q <= WE;
      adr_q <= ADR;
      sel_q <= SEL;
      dat_q <= DAT_M;
    end
  end
  // Commits on the edge that raises ACK; a reset on that edge drops the write
  always_ff @(posedge CLK) begin
    if (RST_N && resp && we_q && !oob)
      for (int i = 0; i < 16; i++)
        if (sel_q[i]) mem[line][8*i +: 8] <= dat_q[8*i +: 8];
  end
endmodule

// File: tb/tb_wb_line_mem_slave.sv
module tb_wb_line_mem_slave;
  localparam int DEPTH = 256;
  localparam int LAT = 3;
  logic CLK = 1'b0, RST_N = 1'b0, CYC = 1'b0, STB = 1'b0, WE = 1'b0;
  logic [11:0] ADR = '0;
  logic [15:0] SEL = '0;
  logic [127:0] DAT_M = '0;
  logic [127:0] DAT_S;
  logic ACK, RTY;
  int n_cmp = 0, n_bad = 0, cyc = 0, exp_cyc = -1, n_ack = 0, exp_n_ack = 0;
  logic exp_rty = 1'b0, chk_en = 1'b0;
  logic [127:0] exp_dat = '0, last_dat = '0;
  logic [127:0] model [DEPTH];
  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0;
  localparam logic [127:0] D3 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D4 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] D5 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D6 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] AA = {16{8'hAA}};

  wb_line_mem_slave #(.DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
    .SEL(SEL), .DAT_M(DAT_M), .DAT_S(DAT_S), .ACK(ACK), .RTY(RTY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] dat, input logic [15:0] sel);
    merge = old;
    for (int i = 0; i < 16; i++) if (sel[i]) merge[8*i +: 8] = dat[8*i +: 8];
  endfunction

  // Response is due LATENCY+2 cycles after the cycle the master drives the request
  always @(negedge CLK) begin
    if (chk_en) begin
      check("ack", 128'(ACK), 128'((cyc == exp_cyc) && !exp_rty));
      check("rty", 128'(RTY), 128'((cyc == exp_cyc) && exp_rty));
      check("dat_s", DAT_S, (cyc == exp_cyc) ? exp_dat : '0);
      if (ACK === 1'b1) begin
        n_ack++;
        last_dat = DAT_S;
      end
    end
  end

  // mode 0: complete transfer, 1: drop STB after one wait cycle, 2: reset pulse during wait
  task automatic txn(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                     input logic [127:0] dat, input int mode);
    int line;
    logic oob;
    line = int'(adr) % DEPTH;
    oob = 1'b0;
`ifdef WB_LINE_MEM_RANGE_CHECK_EN
    oob = int'(adr) >= DEPTH;
`endif
    @(posedge CLK); #1;
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = sel; DAT_M = dat;
    if (mode == 0) begin
      exp_cyc = cyc + LAT + 2;
      exp_rty = oob;
      exp_dat = (we || oob) ? '0 : model[line];
      if (!oob) exp_n_ack++;
      if (we && !oob) model[line] = merge(model[line], dat, sel);
      repeat (LAT + 2) @(posedge CLK);
      #1; CYC = 1'b0; STB = 1'b0;
    end else if (mode == 1) begin
      repeat (2) @(posedge CLK);
      #1; CYC = 1'b0; STB = 1'b0;
    end else begin
      repeat (2) @(posedge CLK);
      #1; RST_N = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b1; CYC = 1'b0; STB = 1'b0;
    end
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    txn(1'b1, 12'h005, 16'hFFFF, D1, 0);
    txn(1'b0, 12'h005, 16'h0000, '0, 0);
    check("full_write_read", last_dat, D1);
    txn(1'b1, 12'h005, 16'hFFFF, AA, 0);
    txn(1'b1, 12'h005, 16'h0003, 128'h1234, 0);
    txn(1'b0, 12'h005, 16'h0000, '0, 0);
    check("byte_mask", last_dat, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA1234);
    txn(1'b0, 12'h010, 16'h0000, '0, 1);
    txn(1'b1, 12'h010, 16'hFFFF, D2, 0);
    txn(1'b0, 12'h010, 16'h0000, '0, 0);
    check("after_abort", last_dat, D2);
    txn(1'b1, 12'h020, 16'hFFFF, D3, 0);
    txn(1'b1, 12'h020, 16'hFFFF, D4, 2);
    txn(1'b0, 12'h020, 16'h0000, '0, 0);
    check("mid_write_reset", last_dat, D3);
    txn(1'b1, 12'h000, 16'hFFFF, D5, 0);
    txn(1'b1, 12'h100, 16'hFFFF, D6, 0);
    txn(1'b0, 12'h000, 16'h0000, '0, 0);
`ifdef WB_LINE_MEM_RANGE_CHECK_EN
    check("range_line0", last_dat, D5);
`else
    check("range_line0", last_dat, D6);
`endif
    txn(1'b1, 12'h005, 16'h0000, D6, 0);
    txn(1'b0, 12'h005, 16'h0000, '0, 0);
    check("sel0_write", last_dat, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA1234);
    check("ack_count", 128'(n_ack), 128'(exp_n_ack));
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
